// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the LED matrix row-scan controller: geometry, row width
// and the scan FSM encoding.
package matrix_scan_ctrl_pkg;

  localparam int MATRIX_SIZE = 8;
  localparam int ROW_W       = $clog2(MATRIX_SIZE);
  localparam int FRAME_W     = MATRIX_SIZE * MATRIX_SIZE;

  // 2'd3 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_DISPLAY = 2'd2
  } scan_state_e;

  // Row index wraps MATRIX_SIZE-1 -> 0 through natural overflow of ROW_W bits.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    return row + 1'b1;
  endfunction

endpackage

// File: rtl/matrix_frame_buf.sv
// Double frame buffer: a shadow register filled by the valid/ready handshake and an
// active register refreshed from it on request, plus the per-row column slice mux.
module matrix_frame_buf
  import matrix_scan_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_valid_i,
  input  logic [FRAME_W-1:0]     load_data_i,
  input  logic                   swap_i,
  input  logic [ROW_W-1:0]       row_i,
  output logic                   ready_o,
  output logic [MATRIX_SIZE-1:0] row_data_o
);

  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic               pending_q, pending_d;
  logic               load;

  assign ready_o = ~pending_q;
  assign load    = load_valid_i & ~pending_q;

  // Load requires pending=0 and swap only acts with pending=1, so they never collide.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = load_data_i;
      pending_d = 1'b1;
    end else if (swap_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    row_data_o = '0;
    for (int r = 0; r < MATRIX_SIZE; r++) begin
      if (row_i == ROW_W'(r)) row_data_o = active_q[r*MATRIX_SIZE +: MATRIX_SIZE];
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for the 8x8 LED matrix: blank/display timing per row, row
// stepping with wrap, frame swap at row 0, and registered decoder/column outputs.
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int ROW_CYC   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   scan_en_i,
  input  logic                   frame_valid_i,
  output logic                   frame_ready_o,
  input  logic [FRAME_W-1:0]     frame_data_i,
  output logic [ROW_W-1:0]       row_sel_o,
  output logic                   row_en_o,
  output logic [MATRIX_SIZE-1:0] col_data_o,
  output logic                   frame_start_o
);

  localparam int CNT_MAX = (ROW_CYC > BLANK_CYC) ? ROW_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ROW_LOAD   = CNT_W'(ROW_CYC);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_e            state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   row_en_q, row_en_d;
  logic [MATRIX_SIZE-1:0] col_q, col_d;
  logic                   fstart_q, fstart_d;
  logic                   swap;
  logic [MATRIX_SIZE-1:0] row_slice;

  matrix_frame_buf u_frame_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_valid_i (frame_valid_i),
    .load_data_i  (frame_data_i),
    .swap_i       (swap),
    .row_i        (row_d),
    .ready_o      (frame_ready_o),
    .row_data_o   (row_slice)
  );

  // Counter loads on state entry and the state is left on the cycle it reads 1.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        row_d = '0;
        cnt_d = '0;
        if (scan_en_i) begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
          swap    = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DISPLAY;
          cnt_d   = ROW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DISPLAY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_BLANK;
          row_d   = next_row(row_q);
          cnt_d   = BLANK_LOAD;
          swap    = (row_d == '0);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (!scan_en_i) begin
      state_d = ST_IDLE;
      row_d   = '0;
      cnt_d   = '0;
      swap    = 1'b0;
    end
  end

  always_comb begin
    row_en_d = (state_d == ST_DISPLAY);
    col_d    = row_en_d ? row_slice : '0;
    fstart_d = (state_d == ST_DISPLAY) && (state_q == ST_BLANK) && (row_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      row_en_q <= 1'b0;
      col_q    <= '0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      row_en_q <= row_en_d;
      col_q    <= col_d;
      fstart_q <= fstart_d;
    end
  end

  assign row_sel_o     = row_q;
  assign row_en_o      = row_en_q;
  assign col_data_o    = col_q;
  assign frame_start_o = fstart_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with ROW_CYC=4, BLANK_CYC=2 (6 cycles/row).
module tb_matrix_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        scan_en;
  logic        frame_valid;
  logic        frame_ready;
  logic [63:0] frame_data;
  logic [2:0]  row_sel;
  logic        row_en;
  logic [7:0]  col_data;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] FRAME_A = 64'h8040_2010_0804_0201;
  localparam logic [63:0] FRAME_B = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FRAME_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FRAME_D = 64'h5A5A_5A5A_5A5A_5A5A;

  matrix_scan_ctrl #(
    .ROW_CYC   (4),
    .BLANK_CYC (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .scan_en_i     (scan_en),
    .frame_valid_i (frame_valid),
    .frame_ready_o (frame_ready),
    .frame_data_i  (frame_data),
    .row_sel_o     (row_sel),
    .row_en_o      (row_en),
    .col_data_o    (col_data),
    .frame_start_o (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},  {63'b0, row_en},      64'd0);
    chk({tag, "_sel"}, {61'b0, row_sel},     64'd0);
    chk({tag, "_col"}, {56'b0, col_data},    64'd0);
    chk({tag, "_fs"},  {63'b0, frame_start}, 64'd0);
  endtask

  // Called on a negedge at cycle index `first` of row r; checks cycles first..last-1
  // (0,1 = blank, 2..5 = display) and returns on the negedge of cycle `last`.
  task automatic scan_row(input int r, input logic [7:0] col, input int first, input int last);
    for (int i = first; i < last; i++) begin
      chk($sformatf("r%0d_c%0d_en", r, i),  {63'b0, row_en},      (i >= 2) ? 64'd1 : 64'd0);
      chk($sformatf("r%0d_c%0d_sel", r, i), {61'b0, row_sel},     64'(r));
      chk($sformatf("r%0d_c%0d_col", r, i), {56'b0, col_data},    (i >= 2) ? {56'b0, col} : 64'd0);
      chk($sformatf("r%0d_c%0d_fs", r, i),  {63'b0, frame_start}, (r == 0 && i == 2) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst         = 1'b0;
    scan_en     = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("rst_async");
    chk("rst_async_rdy", {63'b0, frame_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Load frame A, start scan, one full frame plus wrap
    chk("rdy_before_A", {63'b0, frame_ready}, 64'd1);
    frame_valid = 1'b1;
    frame_data  = FRAME_A;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("rdy_after_A", {63'b0, frame_ready}, 64'd0);
    chk_idle_outputs("idle_pre_scan");
    scan_en = 1'b1;
    @(negedge clk);
    chk("rdy_after_swapA", {63'b0, frame_ready}, 64'd1);
    for (int r = 0; r < 8; r++) scan_row(r, 8'h01 << r, 0, 6);
    scan_row(0, 8'h01, 0, 6);
    scan_row(1, 8'h02, 0, 6);
    scan_row(2, 8'h04, 0, 6);

    // Load B during row 3; A stays until the row 0 swap; held C loads right after
    frame_valid = 1'b1;
    frame_data  = FRAME_B;
    scan_row(3, 8'h08, 0, 6);
    chk("rdy_B_pending", {63'b0, frame_ready}, 64'd0);
    frame_data = FRAME_C;
    scan_row(4, 8'h10, 0, 6);
    scan_row(5, 8'h20, 0, 6);
    scan_row(6, 8'h40, 0, 6);
    chk("rdy_before_wrap", {63'b0, frame_ready}, 64'd0);
    scan_row(7, 8'h80, 0, 6);
    chk("rdy_after_swapB", {63'b0, frame_ready}, 64'd1);
    scan_row(0, 8'hFF, 0, 1);
    chk("rdy_C_loaded", {63'b0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    scan_row(0, 8'hFF, 1, 6);
    for (int r = 1; r < 5; r++) scan_row(r, 8'hFF, 0, 6);

    // Drop scan_en on the 2nd DISPLAY cycle of row 5
    scan_row(5, 8'hFF, 0, 3);
    chk("r5_disp2_en", {63'b0, row_en}, 64'd1);
    scan_en = 1'b0;
    @(negedge clk);
    chk_idle_outputs("drop_en");
    @(negedge clk);
    chk_idle_outputs("drop_en_hold");
    chk("rdy_C_retained", {63'b0, frame_ready}, 64'd0);

    // Re-enable: restart at BLANK row 0, pending C swaps in
    scan_en = 1'b1;
    @(negedge clk);
    chk("rdy_after_swapC", {63'b0, frame_ready}, 64'd1);
    scan_row(0, 8'hEF, 0, 6);
    scan_row(1, 8'hCD, 0, 6);
    frame_valid = 1'b1;
    frame_data  = FRAME_D;
    scan_row(2, 8'hAB, 0, 6);
    frame_valid = 1'b0;
    scan_row(3, 8'h89, 0, 6);
    scan_row(4, 8'h67, 0, 6);
    scan_row(5, 8'h45, 0, 6);

    // Async reset during DISPLAY of row 6 with D pending
    scan_row(6, 8'h23, 0, 3);
    chk("r6_disp_en", {63'b0, row_en}, 64'd1);
    chk("rdy_D_pending", {63'b0, frame_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid_disp");
    chk("rst_mid_rdy", {63'b0, frame_ready}, 64'd1);
    scan_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_rst_idle");

    // Scan with no frame loaded: timing runs, columns stay 0
    scan_en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 8; r++) scan_row(r, 8'h00, 0, 6);
    scan_row(0, 8'h00, 0, 6);
    chk("rdy_no_load", {63'b0, frame_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
